// File: rtl/retire_perf_counters.sv
// retire_perf_counters
// Performance-counter bank on the retire interface. Counts cycles, retired
// instructions, control transfers, mispredicts, loads, stores, traps and
// NUM_USER_EVENTS generic strobes, plus a STATUS word. It has a registered
// one-cycle read port.
//
// Optional feature macro: PERF_SATURATE_EN
//   defined   : counters saturate at all-ones and hold; the overflow flag
//               sets on any increment attempted at all-ones.
//   undefined : counters wrap all-ones -> 0; the overflow flag sets on the
//               wrap and stays set until i_clear or reset.
//
// Counter index map:
//   0 cycles | 1 retired | 2 control transfers | 3 mispredicts
//   4 loads  | 5 stores  | 6 traps             | 7+k user event k
//   7+NUM_USER_EVENTS : STATUS {.., ovf[i] at bit 2+i, frozen, halted}
//   higher indices read as 0
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN    | counting enabled
// ST_FROZEN | counting suspended while i_freeze is high
// ST_HALTED | a halt retired; counting stops until i_clear
module retire_perf_counters #(
    parameter int CNT_WIDTH       = 32,
    parameter int NUM_USER_EVENTS = 4,
    parameter int SEL_WIDTH       = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_retire_valid,
    input  logic [31:0]                i_retire_inst,
    input  logic                       i_retire_halt,
    input  logic                       i_retire_trap,
    input  logic                       i_retire_dmem_ren,
    input  logic                       i_retire_dmem_wen,
    input  logic                       i_mispredict,
    input  logic [NUM_USER_EVENTS-1:0] i_user_event,
    input  logic                       i_freeze,
    input  logic                       i_clear,
    input  logic                       i_rd_en,
    input  logic [SEL_WIDTH-1:0]       i_rd_sel,
    output logic [CNT_WIDTH-1:0]       o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_halted,
    output logic                       o_frozen
);

    localparam int NUM_CNT    = 7 + NUM_USER_EVENTS;
    localparam int STATUS_IDX = NUM_CNT;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FROZEN = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q, ovf_d;

    logic [NUM_CNT-1:0]   event_w;
    logic                 halt_retire_w;
    logic                 count_en_w;
    logic [6:0]           opcode_w;
    logic                 unused_inst_w;

    logic [CNT_WIDTH-1:0] status_w;
    logic [CNT_WIDTH-1:0] rd_mux_w;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q;

    assign opcode_w      = i_retire_inst[6:0];
    assign unused_inst_w = ^i_retire_inst[31:7];
    assign halt_retire_w = i_retire_valid & i_retire_halt;
    assign count_en_w    = (state_q == ST_RUN);

    // Next-state logic; i_clear is the only way out of HALTED and also
    // re-synchronises the state to the freeze level from any state.
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = i_freeze ? ST_FROZEN : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_retire_w)  state_d = ST_HALTED;
                    else if (i_freeze)  state_d = ST_FROZEN;
                end
                ST_FROZEN: begin
                    if (halt_retire_w)  state_d = ST_HALTED;
                    else if (!i_freeze) state_d = ST_RUN;
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Per-counter event strobes for this cycle.
    always_comb begin
        event_w    = '0;
        event_w[0] = 1'b1;
        event_w[1] = i_retire_valid;
        event_w[2] = i_retire_valid &
                     ((opcode_w == OP_BRANCH) || (opcode_w == OP_JAL) ||
                      (opcode_w == OP_JALR));
        event_w[3] = i_mispredict;
        event_w[4] = i_retire_valid & i_retire_dmem_ren;
        event_w[5] = i_retire_valid & i_retire_dmem_wen;
        event_w[6] = i_retire_valid & i_retire_trap;
        for (int k = 0; k < NUM_USER_EVENTS; k++) begin
            event_w[7+k] = i_user_event[k];
        end
    end

    // Counter and overflow next values; clear wins over any event.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i_clear) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (count_en_w && event_w[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
`ifdef PERF_SATURATE_EN
                    cnt_d[i] = cnt_q[i];
`else
                    cnt_d[i] = '0;
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Counter and overflow registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
            ovf_q <= ovf_d;
        end
    end

    // STATUS word assembled from current state and overflow flags.
    always_comb begin
        status_w    = '0;
        status_w[0] = (state_q == ST_HALTED);
        status_w[1] = (state_q == ST_FROZEN);
        for (int i = 0; i < NUM_CNT; i++) begin
            status_w[2+i] = ovf_q[i];
        end
    end

    // Read select; samples pre-update values so a read sees the counter as
    // it was before the same edge's increment.
    always_comb begin
        rd_mux_w = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (i_rd_sel == SEL_WIDTH'(i)) rd_mux_w = cnt_q[i];
        end
        if (i_rd_sel == SEL_WIDTH'(STATUS_IDX)) rd_mux_w = status_w;
        rd_data_d = i_rd_en ? rd_mux_w : rd_data_q;
    end

    // Registered read port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= i_rd_en;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_halted   = (state_q == ST_HALTED);
    assign o_frozen   = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_retire_perf_counters.sv
// Randomised self-checking bench for retire_perf_counters (CNT_WIDTH=16 so
// the wrap/saturate boundary is reachable). The reference model keeps plain
// integer counts per event class and applies the counting rules directly.
module tb_retire_perf_counters;

    localparam int CW = 16;
    localparam int NU = 4;
    localparam int SW = 4;
    localparam int NC = 7 + NU;
    localparam longint unsigned MODV = longint'(1) << CW;

    logic          clk;
    logic          rst;
    logic          retire_valid;
    logic [31:0]   retire_inst;
    logic          retire_halt;
    logic          retire_trap;
    logic          retire_ren;
    logic          retire_wen;
    logic          mispredict;
    logic [NU-1:0] user_event;
    logic          freeze;
    logic          clear;
    logic          rd_en;
    logic [SW-1:0] rd_sel;
    logic [CW-1:0] rd_data;
    logic          rd_valid;
    logic          halted;
    logic          frozen;

    retire_perf_counters #(
        .CNT_WIDTH(CW), .NUM_USER_EVENTS(NU), .SEL_WIDTH(SW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_retire_valid(retire_valid), .i_retire_inst(retire_inst),
        .i_retire_halt(retire_halt), .i_retire_trap(retire_trap),
        .i_retire_dmem_ren(retire_ren), .i_retire_dmem_wen(retire_wen),
        .i_mispredict(mispredict), .i_user_event(user_event),
        .i_freeze(freeze), .i_clear(clear),
        .i_rd_en(rd_en), .i_rd_sel(rd_sel),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_halted(halted), .o_frozen(frozen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: 0 = run, 1 = frozen, 2 = halted
    longint unsigned m_cnt [NC];
    bit              m_ovf [NC];
    int              m_st;
    bit              exp_valid;
    longint unsigned exp_data;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned model_read(input int sel);
        longint unsigned st;
        if (sel < NC) return m_cnt[sel];
        if (sel == NC) begin
            st = 0;
            if (m_st == 2) st |= 1;
            if (m_st == 1) st |= 2;
            for (int i = 0; i < NC; i++) if (m_ovf[i]) st |= (longint'(1) << (2 + i));
            return st;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 0;
        end
        m_st = 0;
        exp_valid = 0;
        exp_data = 0;
    endtask

    task automatic model_edge();
        bit [NC-1:0] ev;
        int op;
        op = int'(retire_inst[6:0]);
        ev[0] = 1;
        ev[1] = retire_valid;
        ev[2] = retire_valid && (op == 'h63 || op == 'h6F || op == 'h67);
        ev[3] = mispredict;
        ev[4] = retire_valid && retire_ren;
        ev[5] = retire_valid && retire_wen;
        ev[6] = retire_valid && retire_trap;
        for (int k = 0; k < NU; k++) ev[7+k] = user_event[k];

        exp_valid = rd_en;
        if (rd_en) exp_data = model_read(int'(rd_sel));

        if (clear) begin
            for (int i = 0; i < NC; i++) begin
                m_cnt[i] = 0;
                m_ovf[i] = 0;
            end
            m_st = freeze ? 1 : 0;
        end else begin
            if (m_st == 0) begin
                for (int i = 0; i < NC; i++) begin
                    if (ev[i]) begin
                        if (m_cnt[i] + 1 >= MODV) begin
                            m_ovf[i] = 1;
`ifndef PERF_SATURATE_EN
                            m_cnt[i] = 0;
`endif
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                end
            end
            if (m_st != 2 && retire_valid && retire_halt) m_st = 2;
            else if (m_st == 0 && freeze)                 m_st = 1;
            else if (m_st == 1 && !freeze)                m_st = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("rd_valid", rd_valid, exp_valid);
        if (exp_valid) check($sformatf("rd_data sel=%0d", rd_sel), rd_data, exp_data);
        check("halted", halted, m_st == 2);
        check("frozen", frozen, m_st == 1);
    endtask

    task automatic idle();
        retire_valid = 0; retire_inst = 32'h13; retire_halt = 0; retire_trap = 0;
        retire_ren = 0; retire_wen = 0; mispredict = 0; user_event = '0;
        clear = 0; rd_en = 0; rd_sel = '0;
    endtask

    task automatic read(input int sel);
        rd_en = 1; rd_sel = SW'(sel);
        step();
        rd_en = 0;
    endtask

    task automatic randomize_cycle();
        logic [31:0] r;
        int pick;
        r = $urandom;
        pick = $urandom_range(0, 5);
        case (pick)
            0: retire_inst = {r[31:7], 7'h63};
            1: retire_inst = {r[31:7], 7'h6F};
            2: retire_inst = {r[31:7], 7'h67};
            default: retire_inst = r;
        endcase
        retire_valid = ($urandom_range(0, 2) != 0);
        retire_halt  = ($urandom_range(0, 199) == 0);
        retire_trap  = ($urandom_range(0, 7) == 0);
        retire_ren   = ($urandom_range(0, 3) == 0);
        retire_wen   = ($urandom_range(0, 3) == 0);
        mispredict   = ($urandom_range(0, 3) == 0);
        user_event   = NU'($urandom);
        if ($urandom_range(0, 29) == 0) freeze = ~freeze;
        clear        = ($urandom_range(0, 119) == 0);
        rd_en        = ($urandom_range(0, 1) == 1);
        rd_sel       = SW'($urandom_range(0, 15));
    endtask

    initial begin
        idle();
        freeze = 0;
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 0);
        check("reset halted", halted, 0);
        check("reset frozen", frozen, 0);
        @(negedge clk);
        rst = 0;

        // 10 cycles, 6 retires, 2 of them jal
        for (int c = 0; c < 10; c++) begin
            retire_valid = (c < 6);
            retire_inst  = (c < 2) ? 32'h0000006F : 32'h00000013;
            step();
        end
        idle();
        read(0); read(1); read(2);
        step();

        // freeze window with retires and a mispredict
        freeze = 1;
        for (int c = 0; c < 5; c++) begin
            retire_valid = (c >= 1 && c <= 3);
            mispredict   = (c == 4);
            step();
        end
        idle();
        read(NC); read(0); read(1); read(3);
        freeze = 0;
        step();
        retire_valid = 1; mispredict = 1;
        step();
        idle();
        read(0); read(1); read(3); read(NC);

        // halt, then events that must not count, then clear
        retire_valid = 1; retire_halt = 1;
        step();
        idle();
        for (int c = 0; c < 6; c++) begin
            retire_valid = 1; mispredict = 1; user_event = '1;
            step();
        end
        idle();
        read(0); read(1); read(NC);
        clear = 1;
        step();
        clear = 0;
        for (int s = 0; s < 16; s++) read(s);

        // randomised traffic
        for (int c = 0; c < 2000; c++) begin
            randomize_cycle();
            step();
        end
        idle();
        freeze = 0;
        clear = 1;
        step();
        clear = 0;

        // drive counter 7 across the 16-bit boundary
        user_event = 4'b0001;
        for (int c = 0; c < 65536; c++) step();
        idle();
        read(7); read(NC);

        // clear together with a retire drops the retire
        clear = 1; retire_valid = 1;
        step();
        idle();
        read(1);

        // asynchronous reset while a read is in flight
        freeze = 1;
        step(); step();
        rd_en = 1; rd_sel = 4'd0;
        step();
        rd_en = 0;
        #2 rst = 1;
        #1;
        model_reset();
        check("async rst rd_valid", rd_valid, 0);
        check("async rst rd_data", rd_data, 0);
        check("async rst frozen", frozen, 0);
        check("async rst halted", halted, 0);
        freeze = 0;
        @(negedge clk);
        rst = 0;
        for (int s = 0; s <= NC; s++) read(s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
